amdchipkill_enc_arbiter: RTL and testbench
==========================================

AMDCHIPKILL_ENC_ARBITER -- requirements
Module: amdchipkill_enc_arbiter

Interface
REQ-001 Parameter MAX_BEATS, default 8, SHALL set the maximum beats per burst; one 64 B line is 8 x 64-bit beats.
REQ-002 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1: reset, SHALL be asynchronous and active-low.
REQ-004 Port enable, input, 1: when low, no new burst SHALL be granted.
REQ-005 Ports a_valid / b_valid, input, 1 each: requester A/B beat valid.
REQ-006 Ports a_ready / b_ready, output, 1 each: requester A/B beat accepted when valid && ready.
REQ-007 Ports a_data / b_data, input, 64 each: dataword; symbol d0 = [63:56] ... d7 = [7:0].
REQ-008 Ports a_last / b_last, input, 1 each: final beat of the burst.
REQ-009 Port out_valid, output, 1: codeword register holds a codeword.
REQ-010 Port out_ready, input, 1: downstream accepts a codeword when out_valid && out_ready.
REQ-011 Port out_codeword, output, 80: {data[63:0], P0[7:0], P1[7:0]}.
REQ-012 Port out_src, output, 1: source of the codeword, 0 = A, 1 = B.
REQ-013 Port out_beat, output, 3: beat index within the burst.
REQ-014 Port out_last, output, 1: codeword ends its burst.
REQ-015 Port err_overrun, output, 1: sticky burst-overrun flag.
REQ-016 Port err_clr, input, 1: clears err_overrun.

Function
REQ-017 Encoding SHALL use one shared instance of the team's RS(10,8) chipkill encoder.
- P0 = XOR of d0..d7.
- P1 = XOR of d_i·α^i over GF(2^8), primitive polynomial 0x15F, α = 0x02.
REQ-018 FSM states SHALL be IDLE, GRANT_A and GRANT_B.
REQ-019 IDLE with enable=1 and any valid SHALL move to GRANT_x on the next cycle; a_ready and b_ready SHALL both be 0 in IDLE (1-cycle arbitration bubble).
REQ-020 Arbitration SHALL be round-robin on a last_grant register.
- Reset value of last_grant SHALL be B, so A wins the first tie.
- If only one requester is valid, it SHALL win.
REQ-021 In GRANT_x, x_ready SHALL equal (!out_valid || out_ready); the other requester's ready SHALL be 0.
REQ-022 Accepting a beat SHALL load the output register on the next edge: codeword, src, beat = beat counter, last.
- Latency is 1 cycle from accept to out_valid.
- A simultaneous drain and load SHALL sustain 1 beat per cycle with no bubble.
REQ-023 out_valid SHALL clear on drain (out_valid && out_ready) when no new beat is loaded; the output register SHALL hold stable while out_valid && !out_ready.
REQ-024 The beat counter SHALL increment on each accepted beat and reset to 0 at burst end.
REQ-025 A burst SHALL end on an accepted beat with x_last=1, or on the accepted beat at index MAX_BEATS-1.
- FSM SHALL go to IDLE and last_grant SHALL become x.
REQ-026 If the beat at index MAX_BEATS-1 is accepted with x_last=0:
- err_overrun SHALL be set;
- out_last for that codeword SHALL be forced to 1;
- further beats from x SHALL be arbitrated as a new burst.
REQ-027 err_clr SHALL clear err_overrun; set SHALL take priority over a clear in the same cycle.
REQ-028 enable deasserted mid-burst SHALL NOT abort the burst; the burst completes, then the FSM stays in IDLE.
REQ-029 A requester SHALL keep data/last stable while valid && !ready; the bench SHALL check this rule on requester inputs (SVA).

Reset
REQ-030 While rst_n=0, all registers SHALL reset asynchronously.
- FSM = IDLE, last_grant = B, beat = 0.
- out_valid = 0, out_codeword = 0, out_src = 0, out_beat = 0, out_last = 0, err_overrun = 0.
- a_ready = b_ready = 0.
REQ-031 Reset asserted mid-burst SHALL discard the output register contents and the partial burst; no codeword SHALL appear after reset release until a new grant.

Verification
REQ-032 A-only beat, data = 0, a_last = 1, out_ready = 1.
- Accept 1 cycle after a_valid rises.
- Next cycle: out_codeword = 80'h0, out_src = 0, out_last = 1.
REQ-033 Encoder check values:
- data = 64'h0100_0000_0000_0000 -> P0 = 8'h01, P1 = 8'h01.
- data = 64'h0000_0000_0000_0001 -> P0 = 8'h01, P1 = 8'h80.
REQ-034 A and B both valid from reset, each sending an 8-beat burst with last on beat 7.
- Outputs: A beats 0..7, one bubble, then B beats 0..7.
- Next tie goes to A.
REQ-035 out_ready held 0 for 5 cycles mid-burst.
- out_codeword stays stable; a_ready = 0.
- On release, no beat is lost or duplicated; out_beat stays sequential.
REQ-036 A sends 9 beats with a_last = 0 on beats 0..7.
- Beat 7: out_last = 1, err_overrun = 1.
- Beat 8 becomes a new burst with out_beat = 0.
- err_clr then clears the flag.
REQ-037 rst_n pulsed low at beat 3 of a burst.
- out_valid = 0 immediately; FSM back in IDLE.
- The first grant after release goes to A.

Source files
------------

// File: rtl/amdchipkill_enc_arbiter.sv
`default_nettype none
// =============================================================================
// amdchipkill_enc_arbiter : round-robin burst arbiter (A/B) feeding one shared
// RS(10,8) chipkill encoder through a 1-deep output register.   Rev 1.0
// =============================================================================

module amdchipkill_rs_enc (
  input  logic [63:0] data,
  output logic [7:0]  p0,
  output logic [7:0]  p1
);

  // Multiply by alpha = 0x02 modulo x^8+x^6+x^4+x^3+x^2+x+1 (0x15F).
  function automatic logic [7:0] xtime(input logic [7:0] v);
    xtime = {v[6:0], 1'b0} ^ (v[7] ? 8'h5F : 8'h00);
  endfunction

  // Horner from d7 down to d0 yields sum(d_i * alpha^i); d7 sits in data[7:0].
  always_comb begin
    p0 = 8'h00;
    p1 = 8'h00;
    for (int j = 0; j < 8; j++) begin
      p0 = p0 ^ data[8*j +: 8];
      p1 = xtime(p1) ^ data[8*j +: 8];
    end
  end

endmodule

module amdchipkill_enc_arbiter #(
  parameter int MAX_BEATS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [63:0] a_data,
  input  logic        a_last,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [63:0] b_data,
  input  logic        b_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [79:0] out_codeword,
  output logic        out_src,
  output logic [2:0]  out_beat,
  output logic        out_last,
  output logic        err_overrun,
  input  logic        err_clr
);

  // MAX_BEATS must lie in 1..8 so the index fits the 3-bit beat field.
  localparam logic [2:0] LAST_IDX = 3'(MAX_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        last_grant;
  logic        last_grant_next;
  logic [2:0]  beat;
  logic [2:0]  beat_next;

  logic        can_load;
  logic        sel_b;
  logic        sel_valid;
  logic [63:0] sel_data;
  logic        sel_last;
  logic        accept;
  logic        at_limit;
  logic        burst_end;
  logic        overrun;
  logic [7:0]  p0;
  logic [7:0]  p1;

  assign can_load  = !out_valid || out_ready;
  assign sel_b     = (state == GRANT_B);
  assign sel_valid = sel_b ? b_valid : a_valid;
  assign sel_data  = sel_b ? b_data  : a_data;
  assign sel_last  = sel_b ? b_last  : a_last;

  assign a_ready   = (state == GRANT_A) && can_load;
  assign b_ready   = (state == GRANT_B) && can_load;
  assign accept    = (state != IDLE) && sel_valid && can_load;
  assign at_limit  = (beat == LAST_IDX);
  assign burst_end = accept && (sel_last || at_limit);
  assign overrun   = accept && at_limit && !sel_last;

  amdchipkill_rs_enc u_enc (
    .data (sel_data),
    .p0   (p0),
    .p1   (p1)
  );

  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    beat_next       = beat;
    case (state)
      IDLE: begin
        // last_grant = 1 means B went last, so A wins a tie.
        if (enable && (a_valid || b_valid)) begin
          if (a_valid && (!b_valid || last_grant)) state_next = GRANT_A;
          else                                     state_next = GRANT_B;
        end
      end
      GRANT_A, GRANT_B: begin
        if (burst_end) begin
          state_next      = IDLE;
          last_grant_next = sel_b;
          beat_next       = 3'd0;
        end else if (accept) begin
          beat_next = beat + 3'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      beat       <= 3'd0;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
      beat       <= beat_next;
    end
  end

  // Load wins over drain, giving one beat per cycle under continuous flow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_codeword <= 80'h0;
      out_src      <= 1'b0;
      out_beat     <= 3'd0;
      out_last     <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_codeword <= {sel_data, p0, p1};
      out_src      <= sel_b;
      out_beat     <= beat;
      out_last     <= sel_last || at_limit;
    end else if (out_ready) begin
      out_valid    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_overrun <= 1'b0;
    else if (overrun) err_overrun <= 1'b1;
    else if (err_clr) err_overrun <= 1'b0;
  end

endmodule
`default_nettype wire

// File: tb/tb_amdchipkill_enc_arbiter.sv
`default_nettype none
// =============================================================================
// tb_amdchipkill_enc_arbiter : directed bench with a transaction-level model
// and scoreboard for amdchipkill_enc_arbiter.   Rev 1.0
// =============================================================================

module tb_amdchipkill_enc_arbiter;

  localparam int MAX_BEATS = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        a_valid, a_ready, a_last;
  logic [63:0] a_data;
  logic        b_valid, b_ready, b_last;
  logic [63:0] b_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [79:0] out_codeword;
  logic        out_src;
  logic [2:0]  out_beat;
  logic        out_last;
  logic        err_overrun;
  logic        err_clr = 1'b0;

  always #5 clk = ~clk;

  amdchipkill_enc_arbiter #(.MAX_BEATS(MAX_BEATS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .a_valid      (a_valid),
    .a_ready      (a_ready),
    .a_data       (a_data),
    .a_last       (a_last),
    .b_valid      (b_valid),
    .b_ready      (b_ready),
    .b_data       (b_data),
    .b_last       (b_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_codeword (out_codeword),
    .out_src      (out_src),
    .out_beat     (out_beat),
    .out_last     (out_last),
    .err_overrun  (err_overrun),
    .err_clr      (err_clr)
  );

  typedef struct { logic [63:0] data; logic last; } beat_t;
  typedef struct { logic [79:0] cw; logic src; logic [2:0] beat; logic last; } exp_t;
  typedef struct { logic [79:0] cw; logic src; logic [2:0] beat; logic last; int cyc; } log_t;

  beat_t aq[$];
  beat_t bq[$];
  exp_t  q[$];
  log_t  log[$];

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Plain shift-and-add GF(2^8) multiply, reduction polynomial 0x15F.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] aa;
    logic [7:0] r;
    aa = {1'b0, a};
    r  = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ aa[7:0];
      aa = aa << 1;
      if (aa[8]) aa = aa ^ 9'h15F;
    end
    return r;
  endfunction

  function automatic logic [79:0] encode(input logic [63:0] d);
    logic [7:0] p0, p1, pw, sym;
    p0 = 8'h00; p1 = 8'h00; pw = 8'h01;
    for (int i = 0; i < 8; i++) begin
      sym = d[63 - 8*i -: 8];
      p0  = p0 ^ sym;
      p1  = p1 ^ gf_mul(sym, pw);
      pw  = gf_mul(pw, 8'h02);
    end
    return {d, p0, p1};
  endfunction

  task automatic push_burst(input bit src, input int n, input logic [63:0] base);
    for (int k = 0; k < n; k++) begin
      beat_t t;
      t.data = base ^ {8'(k), 48'h0, 8'(k * 29)};
      t.last = (k == n - 1);
      if (src) bq.push_back(t);
      else     aq.push_back(t);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_drains(input int n, input int budget);
    int k = 0;
    while (log.size() < n && k < budget) begin
      step(1);
      k++;
    end
    check($sformatf("drain_count_%0d", n), 80'(log.size()), 80'(n));
  endtask

  task automatic wait_beat(input logic [2:0] b, input int budget);
    int k = 0;
    while (!(out_valid && out_beat == b) && k < budget) begin
      step(1);
      k++;
    end
    check("wait_beat", 80'(out_valid && out_beat == b), 80'(1));
  endtask

  // Requester drivers: present the head of the queue, pop it once it was taken.
  initial begin : drv_a
    bit took;
    a_valid = 1'b0; a_data = '0; a_last = 1'b0;
    forever begin
      @(negedge clk);
      took = a_valid && a_ready;
      @(posedge clk);
      #1;
      if (took && aq.size() > 0) void'(aq.pop_front());
      if (aq.size() > 0) begin
        a_valid = 1'b1; a_data = aq[0].data; a_last = aq[0].last;
      end else begin
        a_valid = 1'b0;
      end
    end
  end

  initial begin : drv_b
    bit took;
    b_valid = 1'b0; b_data = '0; b_last = 1'b0;
    forever begin
      @(negedge clk);
      took = b_valid && b_ready;
      @(posedge clk);
      #1;
      if (took && bq.size() > 0) void'(bq.pop_front());
      if (bq.size() > 0) begin
        b_valid = 1'b1; b_data = bq[0].data; b_last = bq[0].last;
      end else begin
        b_valid = 1'b0;
      end
    end
  end

  a_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (a_valid && !a_ready) |=> (a_valid && $stable(a_data) && $stable(a_last)));
  b_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (b_valid && !b_ready) |=> (b_valid && $stable(b_data) && $stable(b_last)));

  // Model state: owner of the open burst (-1 none), beat within it, who went
  // last, who the arbiter must pick next, and the expected sticky error flag.
  int cyc = 0;
  int owner, mbeat, pending;
  bit m_last_grant, bubble, exp_err;

  initial begin : compare
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        q.delete();
        owner = -1; mbeat = 0; pending = -1;
        m_last_grant = 1'b1; bubble = 1'b0; exp_err = 1'b0;
        check("rst_out_valid", 80'(out_valid), 80'(0));
        check("rst_ready", 80'({a_ready, b_ready}), 80'(0));
        check("rst_codeword", out_codeword, 80'h0);
        check("rst_meta", 80'({out_src, out_beat, out_last, err_overrun}), 80'(0));
      end else begin
        bit a_acc, b_acc, src, l, ovr;
        logic [63:0] d;
        a_acc = a_valid && a_ready;
        b_acc = b_valid && b_ready;
        ovr   = 1'b0;
        check("out_valid", 80'(out_valid), 80'(q.size() != 0));
        if (out_valid && q.size() != 0) begin
          check("codeword", out_codeword, q[0].cw);
          check("out_meta", 80'({out_src, out_beat, out_last}),
                80'({q[0].src, q[0].beat, q[0].last}));
        end
        check("err_overrun", 80'(err_overrun), 80'(exp_err));
        check("single_ready", 80'(a_ready && b_ready), 80'(0));
        if (out_valid && !out_ready) check("ready_while_stalled", 80'(a_ready || b_ready), 80'(0));
        if (owner == 0) check("b_ready_in_a_burst", 80'(b_ready), 80'(0));
        if (owner == 1) check("a_ready_in_b_burst", 80'(a_ready), 80'(0));
        if (bubble) check("idle_bubble", 80'(a_ready || b_ready), 80'(0));

        if (out_valid && out_ready && q.size() != 0) begin
          log.push_back('{q[0].cw, q[0].src, q[0].beat, q[0].last, cyc});
          void'(q.pop_front());
        end

        bubble = 1'b0;
        if (a_acc || b_acc) begin
          src = b_acc;
          if (owner < 0) check("grant_src", 80'(src), 80'(pending));
          else           check("burst_owner", 80'(src), 80'(owner));
          owner = src;
          d = src ? b_data : a_data;
          l = src ? b_last : a_last;
          ovr = (mbeat == MAX_BEATS - 1) && !l;
          q.push_back('{encode(d), src, 3'(mbeat), l || (mbeat == MAX_BEATS - 1)});
          if (l || mbeat == MAX_BEATS - 1) begin
            owner = -1; mbeat = 0; pending = -1;
            m_last_grant = src; bubble = 1'b1;
          end else begin
            mbeat++;
          end
        end else if (owner < 0 && enable && (a_valid || b_valid)) begin
          if (a_valid && b_valid) pending = m_last_grant ? 0 : 1;
          else                    pending = a_valid ? 0 : 1;
        end

        if (ovr)          exp_err = 1'b1;
        else if (err_clr) exp_err = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin : main
    // The model's encoder pinned against hand-computed parity.
    check("model_enc_d0", 80'(encode(64'h0100_0000_0000_0000)), 80'({64'h0100_0000_0000_0000, 16'h0101}));
    check("model_enc_d7", 80'(encode(64'h0000_0000_0000_0001)), 80'({64'h0000_0000_0000_0001, 16'h0180}));
    check("model_enc_d1", 80'(encode(64'h0001_0000_0000_0000)), 80'({64'h0001_0000_0000_0000, 16'h0102}));

    // Both requesters queue a full 8-beat burst while still in reset.
    enable = 1'b1;
    push_burst(1'b0, 8, 64'hA5A5_0000_1234_5678);
    push_burst(1'b1, 8, 64'h5A5A_FFFF_8765_4321);
    step(3);
    rst_n = 1'b1;
    wait_drains(16, 80);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("rr_a_%0d", k), 80'({log[k].src, log[k].beat}), 80'({1'b0, 3'(k)}));
      check($sformatf("rr_b_%0d", k), 80'({log[8+k].src, log[8+k].beat}), 80'({1'b1, 3'(k)}));
    end
    check("rr_a_last", 80'({log[6].last, log[7].last}), 80'(2'b01));
    check("rr_b_last", 80'(log[15].last), 80'(1));
    check("rr_no_gap", 80'(log[1].cyc - log[0].cyc), 80'(1));
    check("rr_bubble", 80'(log[8].cyc - log[7].cyc), 80'(2));
    push_burst(1'b0, 1, 64'h1111_2222_3333_4444);
    push_burst(1'b1, 1, 64'h5555_6666_7777_8888);
    wait_drains(18, 30);
    check("rr_next_tie", 80'({log[16].src, log[17].src}), 80'(2'b01));
    step(3);

    // Single zero beat: one bubble cycle before accept, 1-cycle latency.
    log.delete();
    push_burst(1'b0, 1, 64'h0);
    step(1);
    check("single_idle_ready", 80'(a_ready), 80'(0));
    step(1);
    check("single_accept_ready", 80'(a_ready), 80'(1));
    step(1);
    check("single_out_valid", 80'(out_valid), 80'(1));
    check("single_codeword", out_codeword, 80'h0);
    check("single_src_last", 80'({out_src, out_last}), 80'(2'b01));
    step(3);

    // Encoder check values through the DUT.
    log.delete();
    push_burst(1'b0, 1, 64'h0100_0000_0000_0000);
    push_burst(1'b0, 1, 64'h0000_0000_0000_0001);
    wait_drains(2, 30);
    check("dut_parity_d0", 80'(log[0].cw[15:0]), 80'(16'h0101));
    check("dut_parity_d7", 80'(log[1].cw[15:0]), 80'(16'h0180));
    step(3);

    // Downstream stall of 5 cycles mid-burst.
    log.delete();
    push_burst(1'b0, 8, 64'hDEAD_BEEF_CAFE_F00D);
    wait_beat(3'd3, 30);
    out_ready = 1'b0;
    begin
      logic [79:0] snap;
      snap = out_codeword;
      for (int k = 0; k < 5; k++) begin
        step(1);
        check($sformatf("stall_hold_%0d", k), out_codeword, snap);
        check($sformatf("stall_ready_%0d", k), 80'({a_ready, out_valid, out_beat}), 80'({1'b0, 1'b1, 3'd3}));
      end
    end
    out_ready = 1'b1;
    wait_drains(8, 40);
    for (int k = 0; k < 8; k++)
      check($sformatf("stall_seq_%0d", k), 80'({log[k].src, log[k].beat}), 80'({1'b0, 3'(k)}));
    step(3);

    // Overrun: 9 beats with last only on the ninth.
    log.delete();
    push_burst(1'b0, 9, 64'h0F0F_0F0F_F0F0_F0F0);
    wait_drains(9, 50);
    check("ovr_beat7", 80'({log[7].beat, log[7].last}), 80'({3'd7, 1'b1}));
    check("ovr_beat8", 80'({log[8].src, log[8].beat, log[8].last}), 80'({1'b0, 3'd0, 1'b1}));
    check("ovr_flag", 80'(err_overrun), 80'(1));
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("ovr_cleared", 80'(err_overrun), 80'(0));
    // Clear held across a fresh overrun: set must still win for one cycle.
    err_clr = 1'b1;
    log.delete();
    push_burst(1'b0, 9, 64'h7777_0000_7777_0000);
    wait_drains(9, 50);
    step(2);
    err_clr = 1'b0;
    check("ovr_clr_held", 80'(err_overrun), 80'(0));
    step(2);

    // Enable dropped mid-burst: burst completes, next burst waits.
    log.delete();
    push_burst(1'b0, 8, 64'h1234_5678_9ABC_DEF0);
    push_burst(1'b0, 2, 64'h0FED_CBA9_8765_4321);
    wait_beat(3'd2, 30);
    enable = 1'b0;
    wait_drains(8, 40);
    step(6);
    check("en_no_new_burst", 80'({log.size(), a_ready}), 80'({32'(8), 1'b0}));
    enable = 1'b1;
    wait_drains(10, 30);
    check("en_resume", 80'({log[8].beat, log[9].beat, log[9].last}), 80'({3'd0, 3'd1, 1'b1}));
    step(3);

    // Reset pulse at beat 3; first grant afterwards goes to A.
    log.delete();
    push_burst(1'b1, 8, 64'hBBBB_0000_BBBB_0000);
    wait_beat(3'd3, 30);
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 80'(out_valid), 80'(0));
    check("rst_mid_ready", 80'({a_ready, b_ready}), 80'(0));
    aq.delete();
    bq.delete();
    step(2);
    log.delete();
    push_burst(1'b1, 1, 64'hBEEF_0000_0000_0001);
    push_burst(1'b0, 1, 64'hA000_0000_0000_0002);
    rst_n = 1'b1;
    wait_drains(2, 30);
    check("rst_first_grant", 80'({log[0].src, log[1].src}), 80'(2'b01));
    step(4);
    check("final_drained", 80'(q.size()), 80'(0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
